alu_nbit_seq: RTL and testbench



---
 rtl/alu_nbit_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_seq.sv
// N-bit ALU with valid/ready handshakes: single-cycle logic/arith/shift ops and
// an iterative shift-add multiply that stalls the input side for WIDTH cycles.
module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [2:0]       control,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH+1:0]     alu_res;
    logic [2*WIDTH-1:0]   acc_step;

    // Returns {carry, overflow, result} for every single-cycle opcode.
    function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       op);
        logic             sub;
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic [SHW-1:0]   amt;
        sub = (op == 3'b110) || (op == 3'b111);
        bp  = sub ? ~b : b;
        {c, sum} = {1'b0, a} + {1'b0, bp} + {{WIDTH{1'b0}}, sub};
        v   = (a[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        amt = b[SHW-1:0];
        res = '0;
        case (op)
            3'b000: begin res = a & b; c = 1'b0; v = 1'b0; end
            3'b001: begin res = a | b; c = 1'b0; v = 1'b0; end
            3'b010: res = sum;
            3'b011: begin
                res = ({1'b0, amt} >= (SHW+1)'(WIDTH)) ? '0 : (a << amt);
                c = 1'b0; v = 1'b0;
            end
            3'b100: begin
                res = ({1'b0, amt} >= (SHW+1)'(WIDTH)) ? '0 : (a >> amt);
                c = 1'b0; v = 1'b0;
            end
            3'b110: res = sum;
            // Signed less-than must fold in overflow, not just the sign bit.
            3'b111: begin
                res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v};
                c = 1'b0; v = 1'b0;
            end
            default: begin res = '0; c = 1'b0; v = 1'b0; end
        endcase
        return {c, v, res};
    endfunction

    always_comb begin
        alu_res  = alu_eval(dataA, dataB, control);
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (inValid) begin
                    in_ready_d = 1'b0;
                    if (control == 3'b101) begin
                        mcand_d  = {{WIDTH{1'b0}}, dataA};
                        mplier_d = dataB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        data_out_d  = alu_res[WIDTH-1:0];
                        ovf_d       = alu_res[WIDTH];
                        carry_d     = alu_res[WIDTH+1];
                        zero_d      = (alu_res[WIDTH-1:0] == '0);
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    data_out_d  = acc_step[WIDTH-1:0];
                    ovf_d       = |acc_step[2*WIDTH-1:WIDTH];
                    carry_d     = 1'b0;
                    zero_d      = (acc_step[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign dataOut  = data_out_q;
    assign carryOut = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq (WIDTH=8): random and directed ops checked
// against an integer-arithmetic reference model, plus back-pressure and reset cases.
module tb_alu_nbit_seq;
    localparam int W    = 8;
    localparam int UMAX = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [2:0]   control;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] dataOut;
    logic         carryOut;
    logic         overflow;
    logic         zero;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         v;
        logic         z;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rdy_force_en  = 1'b0;
    logic rdy_force_val = 1'b0;
    bit   seen = 1'b0;
    int   first_cyc = 0;
    int   held = 0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .dataA(dataA), .dataB(dataB), .control(control),
        .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
        .carryOut(carryOut), .overflow(overflow), .zero(zero)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, r, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0; r = 0;
        case (op)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: begin
                r = ua + ub; s = sa + sb;
                e.c = (r > UMAX); e.v = (s > SMAX) || (s < SMIN);
            end
            3'd3: r = ua << (ub % W);
            3'd4: r = ua >> (ub % W);
            3'd5: begin r = ua * ub; e.v = (r > UMAX); e.lat = W + 1; end
            3'd6: begin
                r = ua - ub; s = sa - sb;
                e.c = (ua >= ub); e.v = (s > SMAX) || (s < SMIN);
            end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        e.d = W'(r);
        e.z = (e.d == '0);
        return e;
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            chk("accept_timeout", int'(inReady), 1);
            return;
        end
        inValid = 1'b1; dataA = a; dataB = b; control = op;
        @(posedge clk);
        #1;
        e = model(op, a, b);
        e.acc = cyc;
        q.push_back(e);
        inValid = 1'b0;
        dataA = W'($urandom);
        dataB = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || outValid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || outValid) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            outReady = rdy_force_en ? rdy_force_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (outValid) begin
                if (!seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                    held = int'({dataOut, carryOut, overflow, zero});
                end else begin
                    chk("hold_stable", int'({dataOut, carryOut, overflow, zero}), held);
                end
                chk("inready_in_done", int'(inReady), 0);
                if (outReady) begin
                    seen = 1'b0;
                    if (q.size() == 0) begin
                        chk("queue_nonempty", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk("dataOut",  int'(dataOut),  int'(e.d));
                        chk("carryOut", int'(carryOut), int'(e.c));
                        chk("overflow", int'(overflow), int'(e.v));
                        chk("zero",     int'(zero),     int'(e.z));
                        chk("latency",  first_cyc - e.acc + 1, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [2:0]   dop[11] = '{3'd2, 3'd2, 3'd6, 3'd7, 3'd7, 3'd5, 3'd5, 3'd3, 3'd4, 3'd0, 3'd1};
    logic [W-1:0] da[11]  = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h7F, 8'h0D, 8'h10, 8'h81, 8'h81, 8'hF0, 8'hF0};
    logic [W-1:0] db[11]  = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h80, 8'h0B, 8'h10, 8'h03, 8'h07, 8'h3C, 8'h3C};

    initial begin : driver
        int n;
        rst_n = 1'b0; inValid = 1'b0; dataA = '0; dataB = '0; control = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inReady",  int'(inReady),  1);
        chk("rst_outValid", int'(outValid), 0);
        chk("rst_dataOut",  int'(dataOut),  0);
        chk("rst_flags",    int'({carryOut, overflow, zero}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) do_op(dop[i], da[i], db[i]);
        repeat (60) do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        drain();

        // Back-pressure: result held while the consumer stalls, new input ignored.
        rdy_force_en = 1'b1; rdy_force_val = 1'b0;
        @(posedge clk);
        #2;
        do_op(3'd2, 8'h7F, 8'h01);
        chk("bp_valid", int'(outValid), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            inValid = 1'b1; control = 3'd0; dataA = W'($urandom); dataB = W'($urandom);
            @(negedge clk);
            chk("bp_inready", int'(inReady), 0);
            chk("bp_valid_held", int'(outValid), 1);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        rdy_force_val = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(outValid && outReady) && n < 10);
        @(negedge clk);
        chk("inready_after_handoff", int'(inReady), 1);
        chk("valid_after_handoff", int'(outValid), 0);
        rdy_force_en = 1'b0;
        drain();

        // Reset in the middle of a multiply discards it.
        do_op(3'd5, 8'hA5, 8'h3C);
        repeat (4) begin
            @(negedge clk);
            chk("inready_mul", int'(inReady), 0);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_inReady",  int'(inReady),  1);
        chk("arst_outValid", int'(outValid), 0);
        chk("arst_dataOut",  int'(dataOut),  0);
        chk("arst_flags",    int'({carryOut, overflow, zero}), 0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd2, 8'h02, 8'h03);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
